p1c1_serializer: RTL and testbench



---
 rtl/p1c1_serializer.sv | 124 ++++++++++++
 tb/tb_p1c1_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/p1c1_serializer.sv
// p1c1_serializer: parallel-to-serial stimulus stage for the p1c1 sequence circuit.
// Accepts words over a valid/ready handshake and shifts them out one bit per
// enabled clock. It also reports per-bit valid, bit index, frame-done pulse and
// a count of completed frames.
module p1c1_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     load_ready,
    input  logic                     enable,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_count
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic             ser_out_nxt;
    logic             ser_valid_nxt;
    logic [IDX_W-1:0] bit_idx_nxt;
    logic             frame_done_nxt;
    logic [CNT_W-1:0] frame_count_nxt;
    logic             last_consumed;
    logic             transfer;

    // The final bit leaves on an enabled edge, which frees the block for the next word.
    assign last_consumed = (state == SHIFT) && (bit_idx == LAST_IDX) && enable;
    assign load_ready    = !reset && ((state == IDLE) || last_consumed);
    assign transfer      = load_valid && load_ready;

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt       = state;
        shift_nxt       = shift_reg;
        ser_out_nxt     = ser_out;
        ser_valid_nxt   = 1'b0;
        bit_idx_nxt     = bit_idx;
        frame_done_nxt  = 1'b0;
        frame_count_nxt = frame_count;

        case (state)
            IDLE: begin
                ser_out_nxt = IDLE_LEVEL;
            end
            SHIFT: begin
                if (!enable) begin
                    // Stall: hold bit and index, flag the cycle as not carrying a new bit.
                    ser_valid_nxt = 1'b0;
                end else if (bit_idx == LAST_IDX) begin
                    frame_done_nxt  = 1'b1;
                    frame_count_nxt = frame_count + CNT_W'(1);
                    state_nxt       = IDLE;
                    ser_out_nxt     = IDLE_LEVEL;
                    bit_idx_nxt     = '0;
                end else begin
                    bit_idx_nxt   = bit_idx + IDX_W'(1);
                    ser_valid_nxt = 1'b1;
                    if (LSB_FIRST) begin
                        shift_nxt   = shift_reg >> 1;
                        ser_out_nxt = shift_reg[1];
                    end else begin
                        shift_nxt   = shift_reg << 1;
                        ser_out_nxt = shift_reg[WIDTH-2];
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A transfer overrides the above: from IDLE, or back-to-back on the last bit.
        if (transfer) begin
            state_nxt     = SHIFT;
            shift_nxt     = load_data;
            ser_out_nxt   = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
            ser_valid_nxt = 1'b1;
            bit_idx_nxt   = '0;
        end
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            // NOTE: the shift register is a plain register, not a memory, so it takes a reset value too.
            shift_reg   <= '0;
            ser_out     <= IDLE_LEVEL;
            ser_valid   <= 1'b0;
            bit_idx     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            // NOTE: non-blocking assignments here so all registers update together from old values.
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            ser_out     <= ser_out_nxt;
            ser_valid   <= ser_valid_nxt;
            bit_idx     <= bit_idx_nxt;
            frame_done  <= frame_done_nxt;
            frame_count <= frame_count_nxt;
        end
    end

endmodule

// File: tb/tb_p1c1_serializer.sv
// Directed self-checking bench for p1c1_serializer.
// Three instances: default (8-bit, LSB first), CNT_W=2 for counter wrap,
// and 4-bit MSB first.
module tb_p1c1_serializer;

    logic       clk;
    logic       reset;
    logic       lv;
    logic [7:0] ld;
    logic       en;
    logic       lr, so, sv, fd;
    logic [2:0] bi;
    logic [7:0] fc;

    logic       c_lr, c_so, c_sv, c_fd;
    logic [2:0] c_bi;
    logic [1:0] c_fc;

    logic       m_lv;
    logic [3:0] m_ld;
    logic       m_en;
    logic       m_lr, m_so, m_sv, m_fd;
    logic [1:0] m_bi;
    logic [7:0] m_fc;

    int total = 0;
    int bad   = 0;

    p1c1_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .load_valid(lv), .load_data(ld), .load_ready(lr),
        .enable(en), .ser_out(so), .ser_valid(sv), .bit_idx(bi),
        .frame_done(fd), .frame_count(fc)
    );

    p1c1_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .load_valid(lv), .load_data(ld), .load_ready(c_lr),
        .enable(en), .ser_out(c_so), .ser_valid(c_sv), .bit_idx(c_bi),
        .frame_done(c_fd), .frame_count(c_fc)
    );

    p1c1_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .CNT_W(8)) u_m (
        .clk(clk), .reset(reset), .load_valid(m_lv), .load_data(m_ld), .load_ready(m_lr),
        .enable(m_en), .ser_out(m_so), .ser_valid(m_sv), .bit_idx(m_bi),
        .frame_done(m_fd), .frame_count(m_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic [3:0] mw;

        reset = 1'b0;
        lv = 1'b0; ld = 8'h00; en = 1'b1;
        m_lv = 1'b0; m_ld = 4'h0; m_en = 1'b1;

        // Reset state, visible before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_ser_out", so, 0);
        chk("rst_ser_valid", sv, 0);
        chk("rst_bit_idx", bi, 0);
        chk("rst_frame_done", fd, 0);
        chk("rst_frame_count", fc, 0);
        chk("rst_load_ready", lr, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("idle_load_ready", lr, 1);

        // 1: single frame 8'hA5, LSB first.
        w = 8'hA5;
        lv = 1'b1; ld = w;
        cyc();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_ser_out", so, w[i]);
            chk("t1_ser_valid", sv, 1);
            chk("t1_bit_idx", bi, i);
            if (i == 3) chk("t1_ready_mid", lr, 0);
            cyc();
        end
        chk("t1_frame_done", fd, 1);
        chk("t1_frame_count", fc, 1);
        chk("t1_idle_out", so, 0);
        chk("t1_idle_valid", sv, 0);
        cyc();
        chk("t1_done_1cyc", fd, 0);

        // 2: back-to-back 8'hFF then 8'h00.
        do_reset();
        lv = 1'b1; ld = 8'hFF;
        cyc();
        ld = 8'h00;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t2a_ser_out", so, 1);
            chk("t2a_ser_valid", sv, 1);
            chk("t2a_bit_idx", bi, i);
            chk("t2a_load_ready", lr, (i == 7) ? 1 : 0);
            chk("t2a_frame_done", fd, 0);
            cyc();
        end
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t2b_ser_out", so, 0);
            chk("t2b_ser_valid", sv, 1);
            chk("t2b_bit_idx", bi, i);
            chk("t2b_frame_done", fd, (i == 0) ? 1 : 0);
            if (i == 0) chk("t2b_count1", fc, 1);
            cyc();
        end
        chk("t2_frame_done2", fd, 1);
        chk("t2_frame_count", fc, 2);
        chk("t2_idle_valid", sv, 0);

        // 3: three-cycle stall at bit_idx=3 of 8'hA5.
        do_reset();
        w = 8'hA5;
        lv = 1'b1; ld = w;
        cyc();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_ser_out", so, w[i]);
            chk("t3_ser_valid", sv, 1);
            chk("t3_bit_idx", bi, i);
            if (i == 3) begin
                en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    cyc();
                    chk("t3_stall_out", so, 0);
                    chk("t3_stall_idx", bi, 3);
                    chk("t3_stall_valid", sv, 0);
                    chk("t3_stall_done", fd, 0);
                end
                en = 1'b1;
            end
            cyc();
        end
        chk("t3_frame_done", fd, 1);
        chk("t3_frame_count", fc, 1);

        // 4: reset at bit_idx=4 aborts the frame and clears the count.
        cyc();
        w = 8'hA5;
        lv = 1'b1; ld = w;
        cyc();
        lv = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_pre_idx", bi, 4);
        lv = 1'b1; ld = 8'h3C;
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_out", so, 0);
        chk("t4_rst_valid", sv, 0);
        chk("t4_rst_idx", bi, 0);
        chk("t4_rst_count", fc, 0);
        chk("t4_rst_ready", lr, 0);
        cyc();
        chk("t4_rst_done", fd, 0);
        reset = 1'b0;
        #1;
        chk("t4_ready_after", lr, 1);
        w = 8'h3C;
        cyc();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_ser_out", so, w[i]);
            chk("t4_bit_idx", bi, i);
            chk("t4_frame_done", fd, 0);
            cyc();
        end
        chk("t4_frame_done_end", fd, 1);
        chk("t4_frame_count", fc, 1);

        // 5: frame counter wrap with CNT_W=2.
        do_reset();
        for (int f = 0; f < 5; f++) begin
            lv = 1'b1; ld = 8'h5A;
            cyc();
            lv = 1'b0;
            for (int i = 0; i < 8; i++) cyc();
            chk("t5_done", c_fd, 1);
            chk("t5_count_w2", c_fc, (f + 1) % 4);
            chk("t5_count_w8", fc, f + 1);
        end

        // 6: 4-bit MSB first; load_data changes mid-frame.
        do_reset();
        mw = 4'b1000;
        m_lv = 1'b1; m_ld = mw;
        cyc();
        m_lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t6_ser_out", m_so, mw[3-i]);
            chk("t6_ser_valid", m_sv, 1);
            chk("t6_bit_idx", m_bi, i);
            if (i == 1) m_ld = 4'b0111;
            cyc();
        end
        chk("t6_frame_done", m_fd, 1);
        chk("t6_frame_count", m_fc, 1);
        chk("t6_idle_out", m_so, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
